// File: rtl/rand_mem_pkg.sv
// rand_mem_pkg: shared state encoding, default widths and request/response word layouts for the memory read stage
// MEM_READ_SKIP_EN adds a read_flag bit above the request address (FLAG_W=1).
package rand_mem_pkg;
    typedef enum logic [1:0] {IDLE, READ, OUT} rd_state_e;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
`ifdef MEM_READ_SKIP_EN
    localparam int FLAG_W = 1;
    typedef struct packed {
        logic              flag;
        logic [ADDR_W-1:0] addr;
    } rd_req_t;
`else
    localparam int FLAG_W = 0;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
    } rd_req_t;
`endif
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rd_resp_t;
endpackage

// File: rtl/rand_mem_read_module.sv
// rand_mem_read_module: accepts an address, performs one memory read, hands {addr, rdata} downstream
// Ports: clk/rst (sync, active-high); data_i/valid_i/ready_o request from prev stage;
// mem_read/mem_addr/mem_rdata/mem_resp memory side; data_o/valid_o/ready_i response to next stage;
// rd_count counts responses handed downstream (wraps).
// Optional: MEM_READ_SKIP_EN -- data_i[addr_width] is read_flag; flag=0 skips memory and returns data 0.
module rand_mem_read_module
    import rand_mem_pkg::*;
#(
    parameter int addr_width = ADDR_W,
    parameter int data_width = DATA_W,
    parameter int cnt_width  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [addr_width+FLAG_W-1:0]     data_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    output logic                             mem_read,
    output logic [addr_width-1:0]            mem_addr,
    input  logic [data_width-1:0]            mem_rdata,
    input  logic                             mem_resp,
    output logic [addr_width+data_width-1:0] data_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [cnt_width-1:0]             rd_count
);
    localparam logic [cnt_width-1:0] cnt_one = 1;
    rd_state_e             state;
    logic [addr_width-1:0] addr_reg;
    logic [data_width-1:0] rdata_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_reg  <= '0;
            rdata_reg <= '0;
            rd_count  <= '0;
        end else if (state == IDLE) begin
            if (valid_i) begin
                addr_reg <= data_i[addr_width-1:0];
`ifdef MEM_READ_SKIP_EN
                state     <= data_i[addr_width] ? READ : OUT;
                rdata_reg <= data_i[addr_width] ? rdata_reg : '0;
`else
                state <= READ;
`endif
            end
        end else if (state == READ) begin
            if (mem_resp) begin
                rdata_reg <= mem_rdata;
                state     <= OUT;
            end
        end else if (ready_i) begin
            rd_count <= rd_count + cnt_one;
            state    <= IDLE;
        end
    end
    assign ready_o  = state == IDLE;
    assign mem_read = state == READ;
    assign valid_o  = state == OUT;
    assign mem_addr = addr_reg;
    assign data_o   = {addr_reg, rdata_reg};
endmodule

// File: tb/tb_rand_mem_read_module.sv
// tb_rand_mem_read_module: directed checks of the memory read stage with a 4-bit completion counter
module tb_rand_mem_read_module;
    import rand_mem_pkg::*;
    localparam int IW = ADDR_W + FLAG_W;
    logic              clk = 0;
    logic              rst = 1;
    logic [IW-1:0]     data_i = '0;
    logic              valid_i = 0;
    logic              ready_o;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_resp = 0;
    logic [ADDR_W+DATA_W-1:0] data_o;
    logic              valid_o;
    logic              ready_i = 0;
    logic [3:0]        rd_count;
    int tests = 0;
    int fails = 0;
    logic [3:0] exp_cnt;
    logic [ADDR_W+DATA_W-1:0] held;

    rand_mem_read_module #(.cnt_width(4)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .mem_read(mem_read), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        step();
        rst = 0;
        exp_cnt = 0;
        tests++;
        if ({ready_o, mem_read, valid_o} !== 3'b100) begin
            fails++;
            $display("FAIL reset_ctrl: got %b exp 100", {ready_o, mem_read, valid_o});
        end
        tests++;
        if (data_o !== '0 || mem_addr !== '0 || rd_count !== 4'd0) begin
            fails++;
            $display("FAIL reset_regs: data_o %h mem_addr %h rd_count %0d exp all 0", data_o, mem_addr, rd_count);
        end
    endtask

    task automatic test_basic();
        data_i = IW'(64'h1000) | (IW'(FLAG_W) << ADDR_W);
        valid_i = 1;
        step();
        valid_i = 0;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (mem_read !== 1'b1 || mem_addr !== 64'h1000 || ready_o !== 1'b0) begin
                fails++;
                $display("FAIL basic_read%0d: mem_read %b mem_addr %h ready_o %b exp 1 1000 0", i, mem_read, mem_addr, ready_o);
            end
            step();
        end
        mem_rdata = 64'hDEADBEEF;
        mem_resp = 1;
        step();
        mem_resp = 0;
        tests++;
        if (valid_o !== 1'b1 || mem_read !== 1'b0 || data_o !== {64'h1000, 64'hDEADBEEF}) begin
            fails++;
            $display("FAIL basic_out: valid_o %b mem_read %b data_o %h", valid_o, mem_read, data_o);
        end
        ready_i = 1;
        step();
        ready_i = 0;
        exp_cnt++;
        tests++;
        if (rd_count !== exp_cnt || valid_o !== 1'b0 || ready_o !== 1'b1) begin
            fails++;
            $display("FAIL basic_done: rd_count %0d valid_o %b ready_o %b exp %0d 0 1", rd_count, valid_o, ready_o, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        data_i = IW'(64'h2000) | (IW'(FLAG_W) << ADDR_W);
        valid_i = 1;
        step();
        data_i = IW'(64'h3000) | (IW'(FLAG_W) << ADDR_W);
        mem_rdata = 64'h1234;
        mem_resp = 1;
        step();
        mem_resp = 0;
        mem_rdata = 64'hFFFF;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || data_o !== {64'h2000, 64'h1234}) begin
                fails++;
                $display("FAIL bp_hold%0d: valid_o %b ready_o %b data_o %h", i, valid_o, ready_o, data_o);
            end
            step();
        end
        ready_i = 1;
        step();
        ready_i = 0;
        exp_cnt++;
        tests++;
        if (ready_o !== 1'b1 || rd_count !== exp_cnt) begin
            fails++;
            $display("FAIL bp_release: ready_o %b rd_count %0d exp 1 %0d", ready_o, rd_count, exp_cnt);
        end
        step();
        valid_i = 0;
        tests++;
        if (mem_read !== 1'b1 || mem_addr !== 64'h3000) begin
            fails++;
            $display("FAIL bp_next: mem_read %b mem_addr %h exp 1 3000", mem_read, mem_addr);
        end
        mem_rdata = 64'h77;
        mem_resp = 1;
        step();
        mem_resp = 0;
        ready_i = 1;
        step();
        ready_i = 0;
        exp_cnt++;
    endtask

    task automatic test_spurious();
        held = data_o;
        mem_rdata = 64'hBAD;
        mem_resp = 1;
        ready_i = 1;
        step();
        mem_resp = 0;
        ready_i = 0;
        tests++;
        if (data_o !== held || ready_o !== 1'b1 || valid_o !== 1'b0 || rd_count !== exp_cnt) begin
            fails++;
            $display("FAIL spur_idle: data_o %h exp %h ready_o %b valid_o %b rd_count %0d", data_o, held, ready_o, valid_o, rd_count);
        end
        data_i = IW'(64'h4000) | (IW'(FLAG_W) << ADDR_W);
        valid_i = 1;
        step();
        data_i = IW'(64'h5000) | (IW'(FLAG_W) << ADDR_W);
        step();
        tests++;
        if (mem_read !== 1'b1 || mem_addr !== 64'h4000) begin
            fails++;
            $display("FAIL spur_valid_in_read: mem_read %b mem_addr %h exp 1 4000", mem_read, mem_addr);
        end
        mem_rdata = 64'h55;
        mem_resp = 1;
        step();
        mem_resp = 0;
        valid_i = 0;
        tests++;
        if (data_o !== {64'h4000, 64'h55}) begin
            fails++;
            $display("FAIL spur_data: data_o %h exp %h", data_o, {64'h4000, 64'h55});
        end
        ready_i = 1;
        step();
        ready_i = 0;
        exp_cnt++;
        tests++;
        if (rd_count !== exp_cnt) begin
            fails++;
            $display("FAIL spur_count: rd_count %0d exp %0d", rd_count, exp_cnt);
        end
    endtask

    task automatic test_reset_in_read();
        data_i = IW'(64'h6000) | (IW'(FLAG_W) << ADDR_W);
        valid_i = 1;
        step();
        valid_i = 0;
        rst = 1;
        step();
        rst = 0;
        exp_cnt = 0;
        tests++;
        if (mem_read !== 1'b0 || ready_o !== 1'b1 || rd_count !== 4'd0 || data_o !== '0) begin
            fails++;
            $display("FAIL rst_read: mem_read %b ready_o %b rd_count %0d data_o %h", mem_read, ready_o, rd_count, data_o);
        end
        mem_rdata = 64'h99;
        mem_resp = 1;
        step();
        mem_resp = 0;
        step();
        tests++;
        if (valid_o !== 1'b0 || mem_read !== 1'b0 || data_o !== '0) begin
            fails++;
            $display("FAIL rst_late_resp: valid_o %b mem_read %b data_o %h", valid_o, mem_read, data_o);
        end
    endtask

    task automatic test_back_to_back();
        valid_i = 1;
        mem_resp = 1;
        ready_i = 1;
        for (int i = 0; i < 17; i++) begin
            data_i = IW'(64'h100 + i) | (IW'(FLAG_W) << ADDR_W);
            mem_rdata = 64'(i);
            step();
            tests++;
            if (mem_read !== 1'b1 || mem_addr !== 64'h100 + 64'(i)) begin
                fails++;
                $display("FAIL b2b_read%0d: mem_read %b mem_addr %h", i, mem_read, mem_addr);
            end
            step();
            step();
            exp_cnt++;
        end
        valid_i = 0;
        mem_resp = 0;
        ready_i = 0;
        tests++;
        if (rd_count !== 4'd1 || exp_cnt !== 4'd1) begin
            fails++;
            $display("FAIL b2b_wrap: rd_count %0d exp 1", rd_count);
        end
    endtask

`ifdef MEM_READ_SKIP_EN
    task automatic test_skip();
        data_i = {1'b0, 64'h20};
        valid_i = 1;
        step();
        valid_i = 0;
        tests++;
        if (valid_o !== 1'b1 || mem_read !== 1'b0 || data_o !== {64'h20, 64'h0}) begin
            fails++;
            $display("FAIL skip_out: valid_o %b mem_read %b data_o %h", valid_o, mem_read, data_o);
        end
        ready_i = 1;
        step();
        ready_i = 0;
        exp_cnt++;
        tests++;
        if (rd_count !== exp_cnt || mem_read !== 1'b0) begin
            fails++;
            $display("FAIL skip_count: rd_count %0d mem_read %b exp %0d 0", rd_count, mem_read, exp_cnt);
        end
        data_i = {1'b1, 64'h30};
        valid_i = 1;
        step();
        valid_i = 0;
        tests++;
        if (mem_read !== 1'b1 || mem_addr !== 64'h30) begin
            fails++;
            $display("FAIL skip_flag1: mem_read %b mem_addr %h exp 1 30", mem_read, mem_addr);
        end
        mem_rdata = 64'hAB;
        mem_resp = 1;
        step();
        mem_resp = 0;
        tests++;
        if (data_o !== {64'h30, 64'hAB}) begin
            fails++;
            $display("FAIL skip_flag1_data: data_o %h", data_o);
        end
        ready_i = 1;
        step();
        ready_i = 0;
        exp_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_spurious();
        test_reset_in_read();
        test_back_to_back();
`ifdef MEM_READ_SKIP_EN
        test_skip();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
